// File: rtl/instr_prefetch_buffer_if.sv
// Bundles the IF-side fetch handshake and the instruction-memory req/gnt/rvalid port.
// The master modport is the prefetch buffer's view of the bus; slave is its environment.
interface instr_prefetch_buffer_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_ready_i;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  modport master (
    input  req_i, branch_i, branch_addr_i, fetch_ready_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    output instr_req_o, instr_addr_o, busy_o
  );

  modport slave (
    output req_i, branch_i, branch_addr_i, fetch_ready_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    input  instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: keeps up to MAX_OUTSTANDING word fetches in flight,
// queues responses in a DEPTH-entry FIFO and discards everything in flight on a redirect.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
  input logic                     clk_i,
  input logic                     rst_i,
  instr_prefetch_buffer_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned OC_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned RA_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  logic [31:0]      na_q;
  logic [31:0]      addr_q;
  logic             req_q;
  logic [OC_W-1:0]  oc_q;
  logic [OC_W-1:0]  dc_q;
  logic             stl_q;

  fetch_entry_t     fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      ra_q [MAX_OUTSTANDING];
  logic [RA_W-1:0]  ra_wr_q;
  logic [RA_W-1:0]  ra_rd_q;

  logic             gnt_acc;
  logic             hold;
  logic             drop;
  logic             push;
  logic             pop;
  logic             issue;
  logic [OC_W-1:0]  oc_next;
  logic [OC_W-1:0]  dc_next;
  logic [OCC_W-1:0] occ;

  // Issue is judged on next-cycle occupancy so every granted fetch owns a FIFO slot.
  always_comb begin
    gnt_acc = req_q & bus.instr_gnt_i;
    hold    = req_q & ~bus.instr_gnt_i;
    drop    = bus.branch_i | (dc_q != '0);
    push    = bus.instr_rvalid_i & ~drop;
    pop     = (cnt_q != '0) & bus.fetch_ready_i & ~bus.branch_i;
    oc_next = oc_q + OC_W'(gnt_acc) - OC_W'(bus.instr_rvalid_i);
    occ     = OCC_W'(cnt_q) + OCC_W'(push) + OCC_W'(oc_next);
    issue   = bus.req_i & ~bus.branch_i & ~hold
            & (oc_next < OC_W'(MAX_OUTSTANDING))
            & (occ < OCC_W'(DEPTH));
    if (bus.branch_i) begin
      dc_next = oc_next;
    end else begin
      dc_next = dc_q + OC_W'(gnt_acc & stl_q)
              - OC_W'(bus.instr_rvalid_i & (dc_q != '0));
    end
  end

  // Request side: a request once raised is held with a stable address until granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      na_q    <= BOOT_ADDR;
      addr_q  <= BOOT_ADDR;
      req_q   <= 1'b0;
      oc_q    <= '0;
      dc_q    <= '0;
      stl_q   <= 1'b0;
      ra_wr_q <= '0;
      ra_rd_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) ra_q[i] <= '0;
    end else begin
      req_q <= hold | issue;
      oc_q  <= oc_next;
      dc_q  <= dc_next;
      if (issue) addr_q <= na_q;
      if (bus.branch_i) begin
        na_q  <= bus.branch_addr_i & 32'hFFFF_FFFC;
        stl_q <= hold;
      end else begin
        if (issue) na_q <= na_q + 32'd4;
        if (gnt_acc) stl_q <= 1'b0;
      end
      if (gnt_acc) begin
        ra_q[ra_wr_q] <= addr_q;
        ra_wr_q <= (ra_wr_q == RA_W'(MAX_OUTSTANDING - 1)) ? '0 : ra_wr_q + RA_W'(1);
      end
      if (bus.instr_rvalid_i) begin
        ra_rd_q <= (ra_rd_q == RA_W'(MAX_OUTSTANDING - 1)) ? '0 : ra_rd_q + RA_W'(1);
      end
    end
  end

  // Response FIFO; a redirect empties it and wins over any push or pop that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (bus.branch_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{addr: ra_q[ra_rd_q], data: bus.instr_rdata_i};
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign bus.fetch_valid_o = (cnt_q != '0);
  assign bus.fetch_rdata_o = fifo_q[rd_ptr_q].data;
  assign bus.fetch_addr_o  = fifo_q[rd_ptr_q].addr;
  assign bus.instr_req_o   = req_q;
  assign bus.instr_addr_o  = addr_q;
  assign bus.busy_o        = (oc_q != '0) | req_q;

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) bus.instr_rvalid_i |-> (oc_q != '0)
  );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: a reactive memory model plus a transaction-level
// reference of in-flight fetches and queued instructions, driven per scenario.
module tb_instr_prefetch_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_prefetch_buffer_if bus ();

  instr_prefetch_buffer #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .BOOT_ADDR(BOOT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned gcyc;
    bit          stale;
  } inflight_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  int          errors = 0;
  int          checks = 0;
  inflight_t   mq[$];
  entry_t      mf[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_na;
  bit          stale_pending;
  bit          prev_hold;
  logic [31:0] prev_addr;
  int unsigned cyc = 0;
  int          gnt_mode = 0;
  int          rv_mode = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    mq.delete();
    mf.delete();
    exp_na        = BOOT;
    stale_pending = 1'b0;
    prev_hold     = 1'b0;
    prev_addr     = '0;
  endtask

  // One clock: memory responds, outputs are checked, then the model follows the edge.
  task automatic cycle();
    inflight_t f;
    bit gnt, rv, br, pop;
    gnt = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(1, 0) == 1);
    rv  = (mq.size() != 0) && (mq[0].gcyc < cyc) &&
          (rv_mode == 1 || (rv_mode == 2 && $urandom_range(1, 0) == 1));
    bus.instr_gnt_i    = gnt;
    bus.instr_rvalid_i = rv;
    if (rv) bus.instr_rdata_i = mem_data(mq[0].addr);
    else    bus.instr_rdata_i = $urandom();

    checks++;
    if (prev_hold && (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== prev_addr)) begin
      errors++;
      $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", bus.instr_req_o, bus.instr_addr_o, prev_addr);
    end
    checks++;
    if (bus.fetch_valid_o !== (mf.size() != 0)) begin
      errors++;
      $display("FAIL fetch_valid: got %b, required %b (cycle %0d)", bus.fetch_valid_o, mf.size() != 0, cyc);
    end
    if (mf.size() != 0) begin
      checks++;
      if (bus.fetch_addr_o !== mf[0].addr || bus.fetch_rdata_o !== mf[0].data) begin
        errors++;
        $display("FAIL fetch_head: got %h/%h, required %h/%h", bus.fetch_addr_o, bus.fetch_rdata_o, mf[0].addr, mf[0].data);
      end
    end
    checks++;
    if (bus.busy_o !== ((mq.size() != 0) || bus.instr_req_o)) begin
      errors++;
      $display("FAIL busy: got %b, outstanding %0d req %b", bus.busy_o, mq.size(), bus.instr_req_o);
    end
    checks++;
    if (mq.size() > MAXO || mq.size() + mf.size() > DEPTH) begin
      errors++;
      $display("FAIL occupancy: outstanding %0d queued %0d, required <=%0d and sum <=%0d", mq.size(), mf.size(), MAXO, DEPTH);
    end

    br  = bus.branch_i;
    pop = bus.fetch_valid_o && bus.fetch_ready_i && !br && mf.size() != 0;
    if (pop) begin
      pop_log.push_back(mf[0].addr);
      void'(mf.pop_front());
    end
    if (rv) begin
      f = mq.pop_front();
      if (!f.stale && !br) mf.push_back('{addr: f.addr, data: mem_data(f.addr)});
    end
    if (bus.instr_req_o && gnt) begin
      f.addr = bus.instr_addr_o;
      f.gcyc = cyc;
      if (stale_pending) begin
        f.stale = 1'b1;
        stale_pending = 1'b0;
      end else begin
        f.stale = 1'b0;
        checks++;
        if (bus.instr_addr_o !== exp_na) begin
          errors++;
          $display("FAIL grant_addr: got %h, required %h", bus.instr_addr_o, exp_na);
        end
        exp_na = exp_na + 32'd4;
      end
      mq.push_back(f);
      gnt_log.push_back(bus.instr_addr_o);
    end
    if (br) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      mf.delete();
      exp_na        = {bus.branch_addr_i[31:2], 2'b00};
      stale_pending = bus.instr_req_o && !gnt;
    end
    prev_hold = bus.instr_req_o && !gnt;
    prev_addr = bus.instr_addr_o;

    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.branch_i = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_i = 0; bus.branch_i = 0; bus.branch_addr_i = '0; bus.fetch_ready_i = 0;
    bus.instr_gnt_i = 0; bus.instr_rvalid_i = 0; bus.instr_rdata_i = '0;
    gnt_mode = 0; rv_mode = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.req_i = 0; bus.fetch_ready_i = 1; gnt_mode = 1; rv_mode = 1;
    n = 0;
    while ((bus.busy_o || bus.fetch_valid_o) && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (bus.busy_o !== 1'b0 || bus.fetch_valid_o !== 1'b0 || mq.size() != 0) begin
      errors++;
      $display("FAIL drain: busy=%b valid=%b after %0d cycles, required idle", bus.busy_o, bus.fetch_valid_o, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr_req_o !== 1'b0 || bus.instr_addr_o !== BOOT || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem: req=%b addr=%h busy=%b, required 0/%h/0", bus.instr_req_o, bus.instr_addr_o, bus.busy_o, BOOT);
    end
    checks++;
    if (bus.fetch_valid_o !== 1'b0 || bus.fetch_rdata_o !== '0 || bus.fetch_addr_o !== '0) begin
      errors++;
      $display("FAIL reset_fetch: valid=%b rdata=%h addr=%h, required all zero", bus.fetch_valid_o, bus.fetch_rdata_o, bus.fetch_addr_o);
    end
    rst = 1'b0;
    run(3);
    checks++;
    if (bus.instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: req=%b with req_i low, required 0", bus.instr_req_o);
    end
  endtask

  task automatic test_stream();
    int p0;
    apply_reset();
    bus.req_i = 1; bus.fetch_ready_i = 1; gnt_mode = 1; rv_mode = 1;
    run(10);
    p0 = pop_log.size();
    run(20);
    checks++;
    if (pop_log.size() - p0 != 20) begin
      errors++;
      $display("FAIL stream_rate: %0d pops in 20 cycles, required 20", pop_log.size() - p0);
    end
    checks++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'h80 || pop_log[1] !== 32'h84 || pop_log[2] !== 32'h88) begin
      errors++;
      $display("FAIL stream_first: first pops not 80/84/88 (count %0d)", pop_log.size());
    end
    drain();
  endtask

  task automatic test_full();
    int g0;
    apply_reset();
    g0 = gnt_log.size();
    bus.req_i = 1; bus.fetch_ready_i = 0; gnt_mode = 1; rv_mode = 1;
    run(15);
    checks++;
    if (gnt_log.size() - g0 != 4 || bus.instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL full_stop: %0d grants req=%b, required 4 grants req=0", gnt_log.size() - g0, bus.instr_req_o);
    end
    bus.fetch_ready_i = 1;
    cycle();
    bus.fetch_ready_i = 0;
    run(10);
    checks++;
    if (gnt_log.size() - g0 != 5 || gnt_log[gnt_log.size() - 1] !== 32'h90 || bus.instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL full_refill: %0d grants last %h, required 5 grants last 00000090", gnt_log.size() - g0, gnt_log[gnt_log.size() - 1]);
    end
    drain();
  endtask

  task automatic test_stall_branch();
    int g0, p0;
    logic [31:0] held;
    apply_reset();
    bus.req_i = 1; bus.fetch_ready_i = 1; gnt_mode = 1; rv_mode = 1;
    run(6);
    gnt_mode = 0;
    held = bus.instr_addr_o;
    g0 = gnt_log.size();
    checks++;
    if (bus.instr_req_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_req: req=%b at stall start, required 1", bus.instr_req_o);
    end
    run(2);
    bus.branch_i = 1; bus.branch_addr_i = 32'h200;
    cycle();
    p0 = pop_log.size();
    run(2);
    gnt_mode = 1;
    run(20);
    checks++;
    if (gnt_log.size() < g0 + 2 || gnt_log[g0] !== held || gnt_log[g0 + 1] !== 32'h200) begin
      errors++;
      $display("FAIL stall_grants: grants after stall not %h then 00000200", held);
    end
    checks++;
    if (pop_log.size() <= p0 || pop_log[p0] !== 32'h200) begin
      errors++;
      $display("FAIL stall_first_pop: first delivered after branch not 00000200 (pops %0d)", pop_log.size() - p0);
    end
    drain();
  endtask

  task automatic test_branch_flush();
    int n, p0;
    apply_reset();
    bus.req_i = 1; bus.fetch_ready_i = 0; gnt_mode = 1; rv_mode = 0;
    n = 0; while (mq.size() < 2 && n < 20) begin cycle(); n++; end
    gnt_mode = 0; rv_mode = 1;
    n = 0; while ((mf.size() < 2 || mq.size() != 0) && n < 20) begin cycle(); n++; end
    gnt_mode = 1; rv_mode = 0;
    n = 0; while (mq.size() < 2 && n < 20) begin cycle(); n++; end
    checks++;
    if (mq.size() != 2 || mf.size() != 2) begin
      errors++;
      $display("FAIL flush_setup: outstanding %0d queued %0d, required 2 and 2", mq.size(), mf.size());
    end
    gnt_mode = 0;
    bus.fetch_ready_i = 1; bus.branch_i = 1; bus.branch_addr_i = 32'h1003;
    cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: valid=%b after branch, required 0", bus.fetch_valid_o);
    end
    p0 = pop_log.size();
    gnt_mode = 1; rv_mode = 1;
    run(20);
    checks++;
    if (pop_log.size() <= p0 || pop_log[p0] !== 32'h1000) begin
      errors++;
      $display("FAIL flush_first_pop: first delivered after branch not 00001000");
    end
    drain();
  endtask

  task automatic test_branch_rvalid();
    int n, p0, bad;
    logic [31:0] dropped;
    apply_reset();
    bus.req_i = 1; bus.fetch_ready_i = 0; gnt_mode = 1; rv_mode = 0;
    n = 0; while (mq.size() < 2 && n < 20) begin cycle(); n++; end
    gnt_mode = 0; rv_mode = 1;
    cycle();
    dropped = (mq.size() != 0) ? mq[0].addr : 32'hDEAD_BEEF;
    bus.fetch_ready_i = 1; bus.branch_i = 1; bus.branch_addr_i = 32'h400;
    cycle();
    p0 = pop_log.size();
    gnt_mode = 1;
    run(20);
    bad = 0;
    for (int i = p0; i < pop_log.size(); i++) if (pop_log[i] === dropped) bad++;
    checks++;
    if (bad != 0 || pop_log.size() <= p0 || pop_log[p0] !== 32'h400) begin
      errors++;
      $display("FAIL branch_rvalid: dropped %h seen %0d times, first pop must be 00000400", dropped, bad);
    end
    drain();
  endtask

  task automatic test_wrap();
    int p0;
    apply_reset();
    p0 = pop_log.size();
    bus.req_i = 1; bus.fetch_ready_i = 1; gnt_mode = 1; rv_mode = 1;
    bus.branch_i = 1; bus.branch_addr_i = 32'hFFFF_FFF8;
    cycle();
    run(15);
    checks++;
    if (pop_log.size() < p0 + 3 || pop_log[p0] !== 32'hFFFF_FFF8 ||
        pop_log[p0 + 1] !== 32'hFFFF_FFFC || pop_log[p0 + 2] !== 32'h0) begin
      errors++;
      $display("FAIL wrap: sequence after FFFFFFF8 not FFFFFFFC then 00000000");
    end
    drain();
  endtask

  task automatic test_random();
    int p0;
    apply_reset();
    p0 = pop_log.size();
    gnt_mode = 2; rv_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      bus.req_i = ($urandom_range(9, 0) != 0);
      bus.fetch_ready_i = ($urandom_range(3, 0) != 0);
      if ($urandom_range(39, 0) == 0) begin
        bus.branch_i = 1;
        bus.branch_addr_i = $urandom();
      end
      cycle();
    end
    checks++;
    if (pop_log.size() - p0 < 300) begin
      errors++;
      $display("FAIL random_progress: only %0d pops in 3000 cycles, required >=300", pop_log.size() - p0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int p0;
    apply_reset();
    bus.req_i = 1; bus.fetch_ready_i = 0; gnt_mode = 1; rv_mode = 0;
    run(6);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b0 || bus.fetch_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.instr_addr_o !== BOOT) begin
      errors++;
      $display("FAIL reset_mid: req=%b valid=%b busy=%b addr=%h, required 0/0/0/%h",
               bus.instr_req_o, bus.fetch_valid_o, bus.busy_o, bus.instr_addr_o, BOOT);
    end
    apply_reset();
    p0 = pop_log.size();
    bus.req_i = 1; bus.fetch_ready_i = 1; gnt_mode = 1; rv_mode = 1;
    run(10);
    checks++;
    if (pop_log.size() <= p0 || pop_log[p0] !== BOOT) begin
      errors++;
      $display("FAIL reset_mid_restart: first pop after reset not %h", BOOT);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_stream();
    test_full();
    test_stall_branch();
    test_branch_flush();
    test_branch_rvalid();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
